// File: rtl/sap3_pad_pkg.sv
// rtl/sap3_pad_pkg.sv - shared types and constants for the SAP-3 pad bus arbiter
package sap3_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } pad_state_e;

  localparam logic       REQ_CPU      = 1'b0;
  localparam logic       REQ_DBG      = 1'b1;
  localparam logic [7:0] PAD_OE_DRIVE = 8'hFF;

endpackage

// File: rtl/pad_rr_arb2.sv
// rtl/pad_rr_arb2.sv - combinational two-way round-robin grant
module pad_rr_arb2
  import sap3_pad_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  // On a tie the requester not granted last time wins.
  always_comb begin
    grant_valid = |req;
    grant       = REQ_CPU;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[REQ_DBG]) begin
      grant = REQ_DBG;
    end
  end

endmodule

// File: rtl/sap3_pad_arbiter.sv
// rtl/sap3_pad_arbiter.sv - CPU/loader arbiter and phase sequencer for the 8-bit pad bus
module sap3_pad_arbiter
  import sap3_pad_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_ack,
  output logic [7:0]  dbg_rdata,
  output logic [7:0]  pad_out,
  output logic [7:0]  pad_oe,
  input  logic [7:0]  pad_in,
  output logic        pad_ale_h,
  output logic        pad_ale_l,
  output logic        pad_we,
  output logic        pad_re,
  output logic        busy
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  pad_state_e  state;
  pad_state_e  state_nxt;
  logic        last_grant;
  logic        winner;
  logic        txn_we;
  logic [15:0] txn_addr;
  logic [7:0]  txn_wdata;
  logic [3:0]  wait_cnt;
  logic        grant_valid;
  logic        grant;
  logic        read_last;

  pad_rr_arb2 u_arb (
    .req         ({dbg_req, cpu_req}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign read_last = (state == ST_READ) && (wait_cnt == WAIT_LAST);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pads are decoded from state alone, so reset clears them without waiting for a clock.
  always_comb begin
    state_nxt = state;
    pad_out   = 8'h00;
    pad_oe    = 8'h00;
    pad_ale_h = 1'b0;
    pad_ale_l = 1'b0;
    pad_we    = 1'b0;
    pad_re    = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) state_nxt = ST_ADDR_H;
      end
      ST_ADDR_H: begin
        pad_out   = txn_addr[15:8];
        pad_oe    = PAD_OE_DRIVE;
        pad_ale_h = 1'b1;
        state_nxt = ST_ADDR_L;
      end
      ST_ADDR_L: begin
        pad_out   = txn_addr[7:0];
        pad_oe    = PAD_OE_DRIVE;
        pad_ale_l = 1'b1;
        state_nxt = txn_we ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        pad_out   = txn_wdata;
        pad_oe    = PAD_OE_DRIVE;
        pad_we    = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_READ: begin
        pad_re = 1'b1;
        if (read_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cpu_ack   = (winner == REQ_CPU);
        dbg_ack   = (winner == REQ_DBG);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_DBG;
      winner     <= REQ_CPU;
      txn_we     <= 1'b0;
      txn_addr   <= 16'h0000;
      txn_wdata  <= 8'h00;
      wait_cnt   <= 4'd0;
      cpu_rdata  <= 8'h00;
      dbg_rdata  <= 8'h00;
    end else begin
      if (state == ST_IDLE && grant_valid) begin
        winner     <= grant;
        last_grant <= grant;
        txn_we     <= (grant == REQ_DBG) ? dbg_we    : cpu_we;
        txn_addr   <= (grant == REQ_DBG) ? dbg_addr  : cpu_addr;
        txn_wdata  <= (grant == REQ_DBG) ? dbg_wdata : cpu_wdata;
      end
      if (state == ST_ADDR_L) begin
        wait_cnt <= 4'd0;
      end else if (state == ST_READ) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (read_last) begin
        if (winner == REQ_CPU) cpu_rdata <= pad_in;
        else                   dbg_rdata <= pad_in;
      end
    end
  end

endmodule

// File: tb/tb_sap3_pad_arbiter.sv
// tb/tb_sap3_pad_arbiter.sv - directed self-checking bench for sap3_pad_arbiter
module tb_sap3_pad_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, dbg_addr;
  logic [7:0]  cpu_wdata, dbg_wdata, pad_in;
  logic        cpu_ack, dbg_ack, pad_ale_h, pad_ale_l, pad_we, pad_re, busy;
  logic [7:0]  cpu_rdata, dbg_rdata, pad_out, pad_oe;
  logic [22:0] pads;

  int n_cmp = 0;
  int n_bad = 0;

  sap3_pad_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .pad_out(pad_out), .pad_oe(pad_oe), .pad_in(pad_in),
    .pad_ale_h(pad_ale_h), .pad_ale_l(pad_ale_l), .pad_we(pad_we), .pad_re(pad_re),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Flag field order: ale_h ale_l we re cpu_ack dbg_ack busy
  assign pads = {pad_out, pad_oe, pad_ale_h, pad_ale_l, pad_we, pad_re, cpu_ack, dbg_ack, busy};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h9876; cpu_wdata = 8'h01;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h2000; dbg_wdata = 8'h00;
    pad_in = 8'h00;
    tick; tick;
    n_cmp++;
    if (pads !== 23'h0) begin
      n_bad++; $display("FAIL reset_pads got %h want %h", pads, 23'h0);
    end
    n_cmp++;
    if ({cpu_rdata, dbg_rdata} !== 16'h0000) begin
      n_bad++; $display("FAIL reset_rdata got %h want %h", {cpu_rdata, dbg_rdata}, 16'h0000);
    end
    rst_n = 1'b1;
    tick;
    n_cmp++;
    if (pads !== {8'h98, 8'hFF, 7'b1000001}) begin
      n_bad++; $display("FAIL reset_first_grant got %h want %h", pads, {8'h98, 8'hFF, 7'b1000001});
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick; tick; tick;
    n_cmp++;
    if (pads !== {8'h00, 8'h00, 7'b0000101}) begin
      n_bad++; $display("FAIL reset_first_ack got %h want %h", pads, {8'h00, 8'h00, 7'b0000101});
    end
    tick;
  endtask

  task automatic test_cpu_write;
    logic [22:0] exp [6];
    exp[0] = 23'h0;
    exp[1] = {8'h12, 8'hFF, 7'b1000001};
    exp[2] = {8'h34, 8'hFF, 7'b0100001};
    exp[3] = {8'hAB, 8'hFF, 7'b0010001};
    exp[4] = {8'h00, 8'h00, 7'b0000101};
    exp[5] = 23'h0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hAB;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (pads !== exp[c]) begin
        n_bad++; $display("FAIL cpu_write_c%0d got %h want %h", c, pads, exp[c]);
      end
      if (c == 4) cpu_req = 1'b0;
      tick;
    end
  endtask

  task automatic test_dbg_read;
    logic [22:0] exp [7];
    exp[0] = 23'h0;
    exp[1] = {8'hBE, 8'hFF, 7'b1000001};
    exp[2] = {8'hEF, 8'hFF, 7'b0100001};
    exp[3] = {8'h00, 8'h00, 7'b0001001};
    exp[4] = {8'h00, 8'h00, 7'b0001001};
    exp[5] = {8'h00, 8'h00, 7'b0000011};
    exp[6] = 23'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'hBEEF;
    pad_in = 8'h33;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) pad_in = 8'h5A;
      if (c == 5) pad_in = 8'hC7;
      n_cmp++;
      if (pads !== exp[c]) begin
        n_bad++; $display("FAIL dbg_read_c%0d got %h want %h", c, pads, exp[c]);
      end
      if (c == 5) begin
        dbg_req = 1'b0;
        n_cmp++;
        if ({dbg_rdata, cpu_rdata} !== {8'h5A, 8'h00}) begin
          n_bad++; $display("FAIL dbg_read_rdata got %h want %h", {dbg_rdata, cpu_rdata}, {8'h5A, 8'h00});
        end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    bit is_cpu;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1101; cpu_wdata = 8'hC1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h2202; dbg_wdata = 8'hD2;
    for (int c = 0; c < 20; c++) begin
      is_cpu = ((c / 5) % 2) == 0;
      if (c % 5 == 1) begin
        n_cmp++;
        if ({pad_out, pad_ale_h} !== {(is_cpu ? 8'h11 : 8'h22), 1'b1}) begin
          n_bad++; $display("FAIL b2b_addr_c%0d got %h want %h", c, {pad_out, pad_ale_h},
                            {(is_cpu ? 8'h11 : 8'h22), 1'b1});
        end
      end
      if (c % 5 == 4) begin
        n_cmp++;
        if ({cpu_ack, dbg_ack} !== (is_cpu ? 2'b10 : 2'b01)) begin
          n_bad++; $display("FAIL b2b_ack_c%0d got %b want %b", c, {cpu_ack, dbg_ack},
                            (is_cpu ? 2'b10 : 2'b01));
        end
      end
      if (c == 19) begin
        cpu_req = 1'b0; dbg_req = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    logic [22:0] exp [5];
    exp[0] = 23'h0;
    exp[1] = {8'hC3, 8'hFF, 7'b1000001};
    exp[2] = {8'hA5, 8'hFF, 7'b0100001};
    exp[3] = {8'h77, 8'hFF, 7'b0010001};
    exp[4] = {8'h00, 8'h00, 7'b0000101};
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC3A5; cpu_wdata = 8'h77;
    tick; tick;
    n_cmp++;
    if (pads !== exp[2]) begin
      n_bad++; $display("FAIL rmid_addr_l got %h want %h", pads, exp[2]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pads, cpu_rdata, dbg_rdata} !== 39'h0) begin
      n_bad++; $display("FAIL rmid_immediate got %h want %h", {pads, cpu_rdata, dbg_rdata}, 39'h0);
    end
    tick; tick;
    n_cmp++;
    if (pads !== 23'h0) begin
      n_bad++; $display("FAIL rmid_held got %h want %h", pads, 23'h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (pads !== exp[c]) begin
        n_bad++; $display("FAIL rmid_replay_c%0d got %h want %h", c, pads, exp[c]);
      end
      if (c == 4) cpu_req = 1'b0;
      tick;
    end
  endtask

  task automatic test_drop_req;
    logic [22:0] exp [7];
    exp[0] = 23'h0;
    exp[1] = {8'h44, 8'hFF, 7'b1000001};
    exp[2] = {8'h55, 8'hFF, 7'b0100001};
    exp[3] = {8'h66, 8'hFF, 7'b0010001};
    exp[4] = {8'h00, 8'h00, 7'b0000101};
    exp[5] = 23'h0;
    exp[6] = 23'h0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4455; cpu_wdata = 8'h66;
    for (int c = 0; c < 7; c++) begin
      n_cmp++;
      if (pads !== exp[c]) begin
        n_bad++; $display("FAIL drop_req_c%0d got %h want %h", c, pads, exp[c]);
      end
      if (c == 1) begin
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'hFFFF; cpu_wdata = 8'h00;
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_cpu_write;
    test_dbg_read;
    test_back_to_back;
    test_reset_mid;
    test_drop_req;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap3_pad_arbiter.md
# sap3_pad_arbiter

Sequencer and two-way arbiter for the shared 8-bit external-memory pad bus of the SAP-3 tile. It shares one pad bus between two requesters: the CPU memory port and the debug/program loader. Each memory access becomes a fixed phase sequence (address high, address low, write data or read wait), driven on the pads with explicit strobes. It sits between the `top` core/loader logic and the chip I/O (`uio_out`/`uio_oe`/`ui_in`).

## Interface
- `WAIT_CYCLES`, default 1: extra read wait states, range 0..15.
- `clk`  in  1  fast system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_req`, `cpu_we`  in  1 each  CPU request and write-enable; `cpu_we` 0 = read.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse to the CPU.
- `cpu_rdata`  out  8  CPU read data; valid from `cpu_ack` until the next CPU read completes.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: the same signals and widths for the loader port.
- `pad_out`  out  8  pad data/address drive.
- `pad_oe`  out  8  pad output enable; always 8'hFF or 8'h00.
- `pad_in`  in  8  pad read data.
- `pad_ale_h`, `pad_ale_l`  out  1 each  address-high and address-low latch strobes.
- `pad_we`, `pad_re`  out  1 each  write strobe and read strobe.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ADDR_H, ADDR_L, WRITE, READ, DONE.
- IDLE:
  - All pad outputs 0, `pad_oe`=0.
  - If any request is high, arbitrate and latch the winner index, `we`, `addr` and `wdata`, then go to ADDR_H.
  - Requests are sampled only in IDLE.
- Arbitration is round-robin over a `last_grant` bit.
  - A single requester always wins.
  - On a tie, the requester not granted last wins.
  - `last_grant` updates on every grant.
- ADDR_H, 1 cycle: `pad_out`=addr[15:8], `pad_oe`=FF, `pad_ale_h`=1.
- ADDR_L, 1 cycle: `pad_out`=addr[7:0], `pad_oe`=FF, `pad_ale_l`=1.
- After ADDR_L, go to WRITE if `we` is set, else READ.
- WRITE, 1 cycle: `pad_out`=wdata, `pad_oe`=FF, `pad_we`=1, then DONE.
- READ, WAIT_CYCLES+1 cycles:
  - `pad_oe`=0, `pad_re`=1.
  - A 4-bit wait counter tracks the cycles.
  - `pad_in` is captured into the winner's rdata on the last READ edge; then DONE.
- DONE, 1 cycle: the winner's ack=1, pads idle, then IDLE.
- The latched transaction completes even if the requester drops req or changes its inputs mid-transaction. The ack is still pulsed.
- The loser's request stays pending and is served next. Nothing is queued beyond the req level.
- `pad_out` is 0 whenever `pad_oe`=0.

## Timing
- Cycle 0 is the IDLE cycle with req high.
- Write: ADDR_H in cycle 1, ADDR_L in cycle 2, WRITE in cycle 3, ack in cycle 4.
- Read: READ from cycle 3 to 3+WAIT_CYCLES; ack in cycle 4+WAIT_CYCLES.
- Turnaround: for a read, `pad_oe` falls at the start of READ.
- Back-to-back transactions: the minimum gap is one IDLE cycle after DONE.
- Requester handshake: deassert req, or present the next request, on the edge ending the ack cycle. Req still high in the following IDLE cycle is taken as a new request.
- Reset, asserted at any time, takes effect immediately:
  - State goes to IDLE.
  - All outputs go to 0, including rdata, ack, `busy` and `pad_oe`.
  - `last_grant` goes to the dbg value, so the CPU wins the first tie.
  - An in-flight transaction is discarded with no ack.
- Release of reset is synchronous to `clk`. A req held through reset starts a fresh transaction from ADDR_H.

## Structure
- `sap3_pad_pkg` holds:
  - the state enum;
  - requester index constants `REQ_CPU`=0 and `REQ_DBG`=1;
  - `PAD_OE_DRIVE`=8'hFF.
- One sub-module, `pad_rr_arb2`: a combinational 2-input round-robin grant from req[1:0] and `last_grant`. The FSM registers the result.
- The read-wait counter, latched transaction fields and per-port rdata registers live in `sap3_pad_arbiter`.

## Test plan
- Reset: hold `rst_n`=0 with both reqs high -> all outputs 0, `busy`=0. Release -> CPU granted first, ADDR_H starts in the next cycle.
- CPU write 0x1234 <= 0xAB -> pads show 12/ale_h, then 34/ale_l, then AB/`pad_we` with `pad_oe`=FF, in cycles 1-3. `cpu_ack` in cycle 4; `dbg_ack` stays 0.
- dbg read 0xBEEF with WAIT_CYCLES=1 and `pad_in`=0x5A during READ -> `pad_oe`=0 and `pad_re`=1 in cycles 3-4. `dbg_ack` in cycle 5 with `dbg_rdata`=0x5A; `cpu_rdata` unchanged.
- Both reqs held continuously -> grants alternate CPU, dbg, CPU, dbg. Each ack follows its own requester's address on the pads.
- Assert `rst_n` low during ADDR_L -> outputs go to 0 immediately and no ack is issued. After release, the held request replays from ADDR_H with the full address.
- CPU drops `cpu_req` during ADDR_H of a write -> the transaction still completes and `cpu_ack` pulses in cycle 4.
